// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: bit order, segment codes for hex digits, polarity helper.
package seg7_scan_driver_pkg;

  localparam int SEG_A_BIT  = 0;
  localparam int SEG_B_BIT  = 1;
  localparam int SEG_C_BIT  = 2;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 4;
  localparam int SEG_F_BIT  = 5;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // Segment codes, bit 6 = g down to bit 0 = a
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [7:0] seg_polarity(input logic [7:0] v, input bit active_high);
    return active_high ? v : ~v;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational hex nibble to 7-segment decoder (active-high, g..a), shared by display blocks.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: per-digit time slots with leading blank interval,
// frame-coherent input snapshot, leading-zero blanking and registered, polarity-adjusted outputs.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 100000,
  parameter int BLANK_CYCLES    = 1000,
  parameter int SEG_ACTIVE_HIGH = 1,
  parameter int AN_ACTIVE_HIGH  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [7:0] SEG_INACTIVE = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_INACTIVE = (AN_ACTIVE_HIGH != 0) ? '0 : '1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    lz_q, lz_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                  frame_end;
  logic [3:0]            nib_sel;
  logic                  dp_sel, en_sel, sup_sel, show;
  logic [NUM_DIGITS-1:0] lz_sup;
  logic                  zero_run;
  logic [6:0]            seg_dec;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  seg7_decode u_decode (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  always_comb begin
    frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    tick_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);

    // Inputs are captured only at the frame boundary so a whole frame shows one coherent value
    dig_d = dig_q;
    dp_d  = dp_q;
    en_d  = en_q;
    lz_d  = lz_q;
    if (frame_end) begin
      dig_d = digits_in;
      dp_d  = dp_in;
      en_d  = digit_en;
      lz_d  = lz_blank;
    end
  end

  always_comb begin
    // Walk down from the most significant digit; digit 0 is never part of the zero run
    zero_run = 1'b1;
    lz_sup   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run  = zero_run & (dig_q[4*i +: 4] == 4'h0);
      lz_sup[i] = lz_q & zero_run;
    end

    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    en_sel  = 1'b0;
    sup_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel = dig_q[4*i +: 4];
        dp_sel  = dp_q[i];
        en_sel  = en_q[i];
        sup_sel = lz_sup[i];
      end
    end

    show    = (cnt_q >= CNT_BLANK) && en_sel && !sup_sel;
    seg_raw = show ? {dp_sel, seg_dec} : 8'h00;
    an_raw  = show ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_d   = seg_polarity(seg_raw, SEG_ACTIVE_HIGH != 0);
    an_d    = (AN_ACTIVE_HIGH != 0) ? an_raw : ~an_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      seg_q  <= SEG_INACTIVE;
      an_q   <= AN_INACTIVE;
      dig_q  <= '0;
      dp_q   <= '0;
      en_q   <= '0;
      lz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dig_q  <= dig_d;
      dp_q   <= dp_d;
      en_q   <= en_d;
      lz_q   <= lz_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule
